// File: rtl/serial_twos_comp_word.sv
// rtl/serial_twos_comp_word.sv - serial LSB-first two's-complement negate / absolute-value unit
//
// Purpose:
//   Mealy bit-serial negator (PASS until the first 1, then INV) with a
//   per-word parallel result. In that result, mode 0 negates the word and
//   mode 1 gives its absolute value.
//   Optional overflow flag: define TWO_COMP_OVF_EN to enable it.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   in        in   serial data bit, LSB first
//   in_valid  in   in carries a valid bit this cycle
//   mode      in   0 = negate, 1 = absolute value (sampled on bit 0)
//   out       out  serial negated bit, combinational from in
//   out_valid out  equals in_valid
//   word_out  out  parallel result of the last completed word
//   word_done out  one-cycle pulse when word_out updates
//   ovf       out  most-negative-value overflow of the last word (0 if disabled)
module serial_twos_comp_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             mode,
  output logic             out,
  output logic             out_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_done,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_INV  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_buf;
  logic             r_mode;
  logic [WIDTH-1:0] r_word_out;
  logic             r_word_done;

  logic             w_accept;
  logic             w_last;
  logic             w_mode;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_neg;
  logic             w_do_neg;
  logic [WIDTH-1:0] w_res;
  logic             w_unused_buf0;

  assign w_accept = in_valid;
  assign w_last   = (r_cnt == LAST_IDX);
  // Mode is taken live on bit 0 so the whole word sees the value latched there.
  assign w_mode   = (r_cnt == '0) ? mode : r_mode;

  // Right-shifting buffer: after the last bit, bit k sits in position k.
  // The complete word is the buffer shifted once more with the current bit on top.
  assign w_x      = {in, r_buf[WIDTH-1:1]};
  assign w_neg    = ~w_x + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_do_neg = ~w_mode | w_x[WIDTH-1];
  assign w_res    = w_do_neg ? w_neg : w_x;

  // Bit 0 of the old buffer is shifted out when the word completes, so it never reaches w_x.
  assign w_unused_buf0 = r_buf[0];

  // Mealy serial output: copy bits up to and including the first 1, invert after.
  assign out       = in_valid & (in ^ (r_state == ST_INV));
  assign out_valid = in_valid;

  assign word_out  = r_word_out;
  assign word_done = r_word_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_PASS;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_mode      <= 1'b0;
      r_word_out  <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      if (w_accept) begin
        r_buf <= w_x;
        if (r_cnt == '0) begin
          r_mode <= mode;
        end
        if (w_last) begin
          // Each word is negated independently, so the FSM restarts at PASS.
          r_state     <= ST_PASS;
          r_cnt       <= '0;
          r_word_out  <= w_res;
          r_word_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (r_state == ST_PASS && in) begin
            r_state <= ST_INV;
          end
        end
      end
    end
  end

`ifdef TWO_COMP_OVF_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept && w_last) begin
      r_ovf <= (w_x == MOST_NEG) && w_do_neg;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule
